shiftr_seq_ctrl: RTL and testbench

//   Multi-cycle sequencer for wide right shifts built on one shared 8-bit right-shift slice.

---
 rtl/shiftr_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_shiftr_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shiftr_seq_ctrl.sv
// Multi-cycle wide right shifter: one byte-granular move, then one pass per byte through a shared 8-bit slice.
// Build option: define SHIFTR_ARITH_EN to honour in_arith (sign fill); otherwise shifts are always logical.
module shiftr_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int SW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_shamt,
  input  logic             in_arith,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  localparam int NB = WIDTH / 8;
  localparam int KW = (NB > 2) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BYTE, S_BIT, S_DONE} state_t;

  state_t             r_state;
  logic [KW-1:0]      r_k;
  logic [WIDTH-1:0]   r_data;
  logic [SW-1:0]      r_shamt;
  logic               r_fill;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic               r_busy;

  logic               w_fill;
  logic [WIDTH+7:0]   w_ext;
  logic [7:0]         w_cur [NB];
  logic [7:0]         w_nxt [NB];
  logic [7:0]         w_cur_sel;
  logic [7:0]         w_nxt_sel;
  logic [15:0]        w_pair;
  logic [7:0]         w_onehot;
  logic [7:0]         w_slice;
  logic [2*WIDTH-1:0] w_wide;

`ifdef SHIFTR_ARITH_EN
  assign w_fill = in_data[WIDTH-1] & in_arith;
`else
  assign w_fill = 1'b0 & in_arith & in_data[WIDTH-1];
`endif

  // Fill byte sits above the operand so the top byte's incoming bits need no special case.
  assign w_ext = {{8{r_fill}}, r_data};

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_bytes
      assign w_cur[gi] = r_data[gi*8 +: 8];
      assign w_nxt[gi] = w_ext[(gi+1)*8 +: 8];
    end
  endgenerate

  assign w_cur_sel = w_cur[r_k];
  assign w_nxt_sel = w_nxt[r_k];
  assign w_pair    = {w_nxt_sel, w_cur_sel};
  assign w_onehot  = 8'b1 << r_shamt[2:0];

  always_comb begin
    w_slice = '0;
    for (int j = 0; j < 8; j++) begin
      if (w_onehot[j]) w_slice = w_pair[j +: 8];
    end
  end

  assign w_wide = {{WIDTH{r_fill}}, r_data} >> {r_shamt[SW-1:3], 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_data      <= '0;
      r_shamt     <= '0;
      r_fill      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_data     <= in_data;
            r_shamt    <= in_shamt;
            r_fill     <= w_fill;
            r_state    <= S_BYTE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_BYTE: begin
          if (abort) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_data  <= w_wide[WIDTH-1:0];
            r_k     <= '0;
            r_state <= S_BIT;
          end
        end
        S_BIT: begin
          if (abort) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            // Byte k+1 is untouched until the next cycle, so the shift works in place.
            for (int b = 0; b < NB; b++) begin
              if (r_k == KW'(b)) r_data[b*8 +: 8] <= w_slice;
            end
            if (r_k == KW'(NB-1)) r_state <= S_DONE;
            else                  r_k     <= r_k + 1'b1;
          end
        end
        S_DONE: begin
          if (abort || (r_out_valid && out_ready)) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end else if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_data;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
endmodule

// File: tb/tb_shiftr_seq_ctrl.sv
// Bench for shiftr_seq_ctrl (WIDTH=32): directed and randomized shifts checked against a shift model.
module tb_shiftr_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic        in_arith;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

`ifdef SHIFTR_ARITH_EN
  localparam bit ARITH = 1'b1;
`else
  localparam bit ARITH = 1'b0;
`endif

  shiftr_seq_ctrl #(.WIDTH(32), .SW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_arith(in_arith), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Sign-filling shift expressed as complement, logical shift, complement.
  function automatic logic [31:0] model(input logic [31:0] d, input int sh, input logic ar);
    if (ARITH && ar && d[31]) return ~((~d) >> sh);
    return d >> sh;
  endfunction

  task automatic issue(input logic [31:0] d, input logic [4:0] sh, input logic ar, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!in_ready) return;
    in_data = d; in_shamt = sh; in_arith = ar; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ok = 1'b1;
  endtask

  task automatic wait_result(output logic [31:0] d, output int lat, output bit ok);
    lat = 0;
    while (!out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    ok = out_valid;
    d  = out_data;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_directed();
    logic [31:0] td [5];
    logic [4:0]  ts [5];
    logic        ta [5];
    logic [31:0] te [5];
    logic [31:0] got;
    int lat;
    bit ok;
    td[0] = 32'h12345678; ts[0] = 5'd12; ta[0] = 1'b0; te[0] = 32'h00012345;
    td[1] = 32'h80000000; ts[1] = 5'd31; ta[1] = 1'b1; te[1] = ARITH ? 32'hFFFFFFFF : 32'h00000001;
    td[2] = 32'h80000000; ts[2] = 5'd31; ta[2] = 1'b0; te[2] = 32'h00000001;
    td[3] = 32'hDEADBEEF; ts[3] = 5'd0;  ta[3] = 1'b0; te[3] = 32'hDEADBEEF;
    td[4] = 32'hDEADBEEF; ts[4] = 5'd8;  ta[4] = 1'b0; te[4] = 32'h00DEADBE;
    for (int i = 0; i < 5; i++) begin
      issue(td[i], ts[i], ta[i], ok);
      checks++; if (!ok) begin errors++; $display("FAIL directed_accept%0d in_ready timeout", i); end
      wait_result(got, lat, ok);
      $display("txn directed %0d: %h >> %0d arith=%0d -> %h (exp %h) lat=%0d", i, td[i], ts[i], ta[i], got, te[i], lat);
      checks++; if (!ok) begin errors++; $display("FAIL directed_valid%0d out_valid timeout", i); end
      checks++; if (got !== te[i]) begin errors++; $display("FAIL directed_data%0d got %h want %h", i, got, te[i]); end
      checks++; if (lat != 6) begin errors++; $display("FAIL directed_latency%0d got %0d want 6", i, lat); end
      consume();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL directed_release%0d out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] d, got, exp;
    logic [4:0]  sh;
    logic        ar;
    int lat;
    bit ok;
    for (int i = 0; i < 30; i++) begin
      d = $urandom; sh = 5'($urandom_range(0, 31)); ar = 1'($urandom_range(0, 1));
      exp = model(d, int'(sh), ar);
      issue(d, sh, ar, ok);
      checks++; if (!ok) begin errors++; $display("FAIL random_accept%0d in_ready timeout", i); end
      wait_result(got, lat, ok);
      $display("txn random %0d: %h >> %0d arith=%0d -> %h (exp %h) lat=%0d", i, d, sh, ar, got, exp, lat);
      checks++; if (got !== exp || !ok) begin errors++; $display("FAIL random_data%0d got %h want %h", i, got, exp); end
      checks++; if (lat != 6) begin errors++; $display("FAIL random_latency%0d got %0d want 6", i, lat); end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      checks++; if (out_data !== exp) begin errors++; $display("FAIL random_hold%0d got %h want %h", i, out_data, exp); end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got;
    int lat;
    bit ok;
    issue(32'hA5C3F00F, 5'd13, 1'b1, ok);
    wait_result(got, lat, ok);
    $display("txn backpressure: a5c3f00f >> 13 -> %h (exp %h)", got, model(32'hA5C3F00F, 13, 1'b1));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== model(32'hA5C3F00F, 13, 1'b1)) begin
        errors++; $display("FAIL bp_stable%0d valid=%b data=%h want 1/%h", i, out_valid, out_data, model(32'hA5C3F00F, 13, 1'b1));
      end
      checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_flags%0d in_ready=%b busy=%b want 0/1", i, in_ready, busy);
      end
    end
    consume();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release valid=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_abort();
    logic [31:0] got;
    int lat;
    bit ok;
    bit seen = 1'b0;
    issue(32'h13579BDF, 5'd9, 1'b0, ok);
    repeat (3) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    $display("txn abort in BIT2: busy=%b in_ready=%b out_valid=%b", busy, in_ready, out_valid);
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL abort_bit busy=%b in_ready=%b want 0/1", busy, in_ready);
    end
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen) begin errors++; $display("FAIL abort_no_valid got pulse want none"); end
    issue(32'h13579BDF, 5'd9, 1'b0, ok);
    wait_result(got, lat, ok);
    abort = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; out_ready = 1'b0;
    $display("txn abort in DONE: out_valid=%b in_ready=%b", out_valid, in_ready);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || !ok) begin
      errors++; $display("FAIL abort_done valid=%b in_ready=%b ok=%0d want 0/1/1", out_valid, in_ready, ok);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    int lat;
    bit ok;
    issue(32'h7777AAAA, 5'd19, 1'b0, ok);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    $display("txn reset in BIT1: valid=%b ready=%b busy=%b data=%h", out_valid, in_ready, busy, out_data);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0) begin
      errors++; $display("FAIL mid_reset valid=%b ready=%b busy=%b data=%h want all 0", out_valid, in_ready, busy, out_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(32'hF0000000, 5'd4, 1'b0, ok);
    wait_result(got, lat, ok);
    $display("txn after reset: f0000000 >> 4 -> %h (exp 0f000000) lat=%0d", got, lat);
    checks++; if (got !== 32'h0F000000 || !ok) begin errors++; $display("FAIL post_reset_data got %h want 0f000000", got); end
    checks++; if (lat != 6) begin errors++; $display("FAIL post_reset_latency got %0d want 6", lat); end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    int lat;
    bit ok;
    issue(32'hCAFEBABE, 5'd3, 1'b1, ok);
    wait_result(got, lat, ok);
    $display("txn b2b first: cafebabe >> 3 -> %h (exp %h)", got, model(32'hCAFEBABE, 3, 1'b1));
    checks++; if (got !== model(32'hCAFEBABE, 3, 1'b1)) begin
      errors++; $display("FAIL b2b_first got %h want %h", got, model(32'hCAFEBABE, 3, 1'b1));
    end
    in_data = 32'h8BADF00D; in_shamt = 5'd27; in_arith = 1'b1; in_valid = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_done_ready got %b want 0", in_ready); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_idle busy=%b ready=%b valid=%b want 0/1/0", busy, in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy=%b want 1", busy); end
    wait_result(got, lat, ok);
    $display("txn b2b second: 8badf00d >> 27 -> %h (exp %h) lat=%0d", got, model(32'h8BADF00D, 27, 1'b1), lat);
    checks++; if (got !== model(32'h8BADF00D, 27, 1'b1) || !ok) begin
      errors++; $display("FAIL b2b_second got %h want %h", got, model(32'h8BADF00D, 27, 1'b1));
    end
    checks++; if (lat != 6) begin errors++; $display("FAIL b2b_latency got %0d want 6", lat); end
    consume();
  endtask

  initial begin
    in_valid = 1'b0; in_data = '0; in_shamt = '0; in_arith = 1'b0;
    abort = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
